// File: rtl/eeprom_slave_pkg.sv
// Shared types and constants for the two-wire EEPROM responder.
package eeprom_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    ADDR,
    ACK_ADDR,
    WDATA,
    ACK_WDATA,
    RDATA,
    RACK
  } state_e;

  localparam logic [3:0]  DEV_CODE      = 4'b1010;
  localparam logic        RW_READ       = 1'b1;
  localparam logic        RW_WRITE      = 1'b0;
  localparam int unsigned DEF_ADDR_W    = 11;
  localparam int unsigned DEF_PAGE_BITS = 4;

endpackage

// File: rtl/eeprom_slave_if.sv
// Bus-side signals of the EEPROM responder: serial clock in, status and write-commit out.
interface eeprom_slave_if #(
  parameter int unsigned ADDR_W = eeprom_bus_pkg::DEF_ADDR_W
);
  logic              SCL;
  logic              BUSY;
  logic              WR_STB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  modport master (output SCL, input BUSY, WR_STB, WR_ADDR, WR_DATA);
  modport slave  (input SCL, output BUSY, WR_STB, WR_ADDR, WR_DATA);
endinterface

// File: rtl/eeprom_slave_bus_sync_edge.sv
// Two-flop synchronizers for SCL/SDA with edge pulses and START/STOP detection.
module bus_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);
  import eeprom_bus_pkg::*;

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic sda_rise, sda_fall;

  // Idle bus is high on both lines, so reset to 1 to avoid spurious edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise_o = scl_s2_q & ~scl_prev_q;
  assign scl_fall_o = ~scl_s2_q & scl_prev_q;
  assign sda_rise   = sda_s2_q & ~sda_prev_q;
  assign sda_fall   = ~sda_s2_q & sda_prev_q;
  assign start_o    = sda_fall & scl_s2_q;
  assign stop_o     = sda_rise & scl_s2_q;
  assign sda_o      = sda_s2_q;

endmodule

// File: rtl/eeprom_slave.sv
// Serial-EEPROM responder: byte/page write, random and sequential read over SCL/SDA.
// state | meaning: IDLE wait START; DEV/ADDR/WDATA shift byte; ACK_* drive ack bit;
// RDATA drive read byte; RACK sample master ack.
module eeprom_slave #(
  parameter int unsigned ADDR_W    = eeprom_bus_pkg::DEF_ADDR_W,
  parameter logic [3:0]  DEV_CODE  = eeprom_bus_pkg::DEV_CODE,
  parameter int unsigned PAGE_BITS = eeprom_bus_pkg::DEF_PAGE_BITS
) (
  input  logic          CLK,
  input  logic          RESET,
  inout  wire           SDA,
  eeprom_slave_if.slave bus
);
  import eeprom_bus_pkg::*;

  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  logic sda_s, start, stop, scl_rise, scl_fall;

  bus_sync_edge u_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .scl_i      (bus.SCL),
    .sda_i      (SDA),
    .sda_o      (sda_s),
    .start_o    (start),
    .stop_o     (stop),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rw_q;
  logic              ack_phase_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        mem [MEM_DEPTH];

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic       last_bit;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign rd_byte  = mem[ptr_q];
  assign last_bit = (bit_cnt_q == 3'd7);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      ptr_q       <= '0;
      rw_q        <= RW_WRITE;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_stb_q <= 1'b0;
      if (start) begin
        state_q     <= DEV;
        bit_cnt_q   <= 3'd0;
        ack_phase_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b1;
      end else if (stop) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          DEV: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (rx_byte[7:4] == DEV_CODE) begin
                ptr_q[ADDR_W-1:8] <= rx_byte[ADDR_W-8:1];
                rw_q              <= rx_byte[0];
                state_q           <= ACK_DEV;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          ADDR: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              ptr_q[7:0] <= rx_byte;
              state_q    <= ACK_ADDR;
            end
          end
          WDATA: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_data_q <= rx_byte;
              ptr_q[PAGE_BITS-1:0] <= ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
              state_q   <= ACK_WDATA;
            end
          end
          // First fall after the 8th bit launches the ack; the next one ends it.
          ACK_DEV, ACK_ADDR, ACK_WDATA: if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_q    <= 1'b1;
              ack_phase_q <= 1'b1;
            end else begin
              ack_phase_q <= 1'b0;
              bit_cnt_q   <= 3'd0;
              sda_oe_q    <= 1'b0;
              if (state_q == ACK_DEV && rw_q == RW_READ) begin
                state_q  <= RDATA;
                shift_q  <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
              end else if (state_q == ACK_DEV) begin
                state_q <= ADDR;
              end else begin
                state_q <= WDATA;
              end
            end
          end
          RDATA: if (scl_fall) begin
            if (last_bit) begin
              sda_oe_q    <= 1'b0;
              ack_phase_q <= 1'b0;
              state_q     <= RACK;
            end else begin
              shift_q   <= {shift_q[6:0], shift_q[7]};
              sda_oe_q  <= ~shift_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
          RACK: begin
            if (scl_rise && !ack_phase_q) begin
              if (!sda_s) begin
                ptr_q       <= ptr_q + ADDR_W'(1);
                ack_phase_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else if (scl_fall && ack_phase_q) begin
              ack_phase_q <= 1'b0;
              shift_q     <= rd_byte;
              sda_oe_q    <= ~rd_byte[7];
              bit_cnt_q   <= 3'd0;
              state_q     <= RDATA;
            end
          end
          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_stb_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.BUSY    = busy_q;
  assign bus.WR_STB  = wr_stb_q;
  assign bus.WR_ADDR = wr_addr_q;
  assign bus.WR_DATA = wr_data_q;

endmodule

// File: tb/tb_eeprom_slave.sv
// Directed bench for eeprom_slave: bit-banged bus master with write/read scoreboards.
module tb_eeprom_slave;
  import eeprom_bus_pkg::*;

  localparam int Q = 5;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic CLK = 1'b0;
  logic RESET;
  logic m_sda_low;
  wire  sda_w;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  wr_t wr_exp[$];
  logic [7:0] rd_exp[$];

  eeprom_slave_if #(.ADDR_W(11)) bus ();

  pullup (sda_w);
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  eeprom_slave #(.ADDR_W(11), .DEV_CODE(4'b1010), .PAGE_BITS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .SDA   (sda_w),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && bus.WR_STB === 1'b1) begin
      logic [19:0] e;
      wr_count++;
      e = (wr_exp.size() != 0) ? {1'b1, wr_exp.pop_front()} : 20'd0;
      check("wr_commit", {12'd0, 1'b1, bus.WR_ADDR, bus.WR_DATA}, {12'd0, e});
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge CLK);
    #1;
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0; qwait();
    bus.SCL = 1'b1;   qwait();
    m_sda_low = 1'b1; qwait();
    bus.SCL = 1'b0;   qwait();
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; qwait();
    bus.SCL = 1'b1;   qwait();
    m_sda_low = 1'b0; qwait();
    qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; qwait();
      bus.SCL = 1'b1;    qwait(); qwait();
      bus.SCL = 1'b0;    qwait();
    end
    m_sda_low = 1'b0; qwait();
    bus.SCL = 1'b1;   qwait();
    ack = sda_w;      qwait();
    bus.SCL = 1'b0;   qwait();
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b, output logic line9);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      qwait();
      bus.SCL = 1'b1; qwait();
      b[i] = sda_w;   qwait();
      bus.SCL = 1'b0; qwait();
    end
    m_sda_low = ~mack; qwait();
    bus.SCL = 1'b1;    qwait();
    line9 = sda_w;     qwait();
    bus.SCL = 1'b0;    qwait();
    m_sda_low = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, l9;
    logic [7:0] rb;
    int wc0;

    RESET = 1'b1; bus.SCL = 1'b1; m_sda_low = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("rst_busy",    bus.BUSY,    0);
    check("rst_wr_stb",  bus.WR_STB,  0);
    check("rst_wr_addr", bus.WR_ADDR, 0);
    check("rst_wr_data", bus.WR_DATA, 0);
    check("rst_sda",     sda_w,       1);
    RESET = 1'b0;
    qwait();

    // Byte write 0x23C <= 0x5A
    wc0 = wr_count;
    start_cond();
    check("bw_busy_start", bus.BUSY, 1);
    send_byte(8'hA4, ack); check("bw_ack_dev", ack, 0);
    send_byte(8'h3C, ack); check("bw_ack_addr", ack, 0);
    wr_exp.push_back('{addr: 11'h23C, data: 8'h5A});
    send_byte(8'h5A, ack); check("bw_ack_data", ack, 0);
    check("bw_busy_pre_stop", bus.BUSY, 1);
    stop_cond();
    check("bw_busy_stop", bus.BUSY, 0);
    check("bw_wr_count", wr_count - wc0, 1);

    // Random read of 0x23C, master NACK
    wc0 = wr_count;
    start_cond();
    send_byte(8'hA4, ack); check("rr_ack_dev_w", ack, 0);
    send_byte(8'h3C, ack); check("rr_ack_addr", ack, 0);
    start_cond();
    send_byte(8'hA5, ack); check("rr_ack_dev_r", ack, 0);
    rd_exp.push_back(8'h5A);
    recv_byte(1'b1, rb, l9);
    check("rr_data", rb, rd_exp.pop_front());
    check("rr_released", l9, 1);
    stop_cond();
    check("rr_no_write", wr_count - wc0, 0);
    check("rr_busy", bus.BUSY, 0);

    // Page wrap 0x00E, 0x00F, 0x000
    wc0 = wr_count;
    wr_exp.push_back('{addr: 11'h00E, data: 8'h11});
    wr_exp.push_back('{addr: 11'h00F, data: 8'h22});
    wr_exp.push_back('{addr: 11'h000, data: 8'h33});
    start_cond();
    send_byte(8'hA0, ack); check("pw_ack_dev", ack, 0);
    send_byte(8'h0E, ack); check("pw_ack_addr", ack, 0);
    send_byte(8'h11, ack); check("pw_ack_d0", ack, 0);
    send_byte(8'h22, ack); check("pw_ack_d1", ack, 0);
    send_byte(8'h33, ack); check("pw_ack_d2", ack, 0);
    stop_cond();
    check("pw_wr_count", wr_count - wc0, 3);

    // Sequential read across the top of memory
    wr_exp.push_back('{addr: 11'h7FF, data: 8'hAA});
    start_cond();
    send_byte(8'hAE, ack); send_byte(8'hFF, ack); send_byte(8'hAA, ack);
    check("sr_ack_pre0", ack, 0);
    stop_cond();
    wr_exp.push_back('{addr: 11'h000, data: 8'hBB});
    start_cond();
    send_byte(8'hA0, ack); send_byte(8'h00, ack); send_byte(8'hBB, ack);
    check("sr_ack_pre1", ack, 0);
    stop_cond();
    wc0 = wr_count;
    start_cond();
    send_byte(8'hAE, ack); send_byte(8'hFF, ack);
    start_cond();
    send_byte(8'hAF, ack); check("sr_ack_dev_r", ack, 0);
    rd_exp.push_back(8'hAA);
    rd_exp.push_back(8'hBB);
    recv_byte(1'b0, rb, l9);
    check("sr_data0", rb, rd_exp.pop_front());
    recv_byte(1'b1, rb, l9);
    check("sr_data1", rb, rd_exp.pop_front());
    check("sr_released", l9, 1);
    stop_cond();
    check("sr_no_write", wr_count - wc0, 0);

    // Wrong device code
    wc0 = wr_count;
    start_cond();
    send_byte(8'h94, ack); check("wc_nack", ack, 1);
    check("wc_busy_idle", bus.BUSY, 0);
    send_byte(8'h00, ack); check("wc_nack_next", ack, 1);
    stop_cond();
    check("wc_no_write", wr_count - wc0, 0);

    // Reset while the slave drives a 0 data bit
    start_cond();
    send_byte(8'hA4, ack); send_byte(8'h3C, ack);
    start_cond();
    send_byte(8'hA5, ack); check("rs_ack_dev_r", ack, 0);
    check("rs_driving_low", sda_w, 0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rs_sda_released", sda_w, 1);
    check("rs_busy", bus.BUSY, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    stop_cond();
    wc0 = wr_count;
    wr_exp.push_back('{addr: 11'h055, data: 8'h66});
    start_cond();
    send_byte(8'hA0, ack); check("rs_bw_ack_dev", ack, 0);
    send_byte(8'h55, ack); check("rs_bw_ack_addr", ack, 0);
    send_byte(8'h66, ack); check("rs_bw_ack_data", ack, 0);
    stop_cond();
    check("rs_bw_count", wr_count - wc0, 1);

    check("wr_queue_left", wr_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
